// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy interrupt controller: IE/IF/IME state, priority resolution and
// the five M-cycle dispatch sequence feeding the register file.
module gb_cpu_interrupt_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  irq_req,
    input  logic        bus_wren,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        ei_cmd,
    input  logic        di_cmd,
    input  logic        reti_cmd,
    input  logic        last_m_cycle,
    input  logic        halt,
    output logic [7:0]  ie_reg,
    output logic [7:0]  if_reg,
    output logic        ime,
    output logic        interrupt_queued,
    output logic        interrupt_queued_no_IME,
    output logic        dispatch_active,
    output logic [2:0]  dispatch_step,
    output logic        write_interrupt_vector,
    output logic [7:0]  interrupt_vector
);

    typedef enum logic [2:0] {
        IDLE = 3'd0, D1 = 3'd1, D2 = 3'd2, D3 = 3'd3, D4 = 3'd4, D5 = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ie_q, ie_d;
    logic [4:0]  if_q, if_d;
    logic        ime_q, ime_d;
    logic        ime_pend_q, ime_pend_d;
    logic [7:0]  vec_q, vec_d;
    logic [4:0]  clr_q, clr_d;

    logic        ie_wr, if_wr, any_pending, start, active;
    logic [4:0]  pending, dispatch_clear, pend_resolve;

    always_comb begin
        ie_wr          = bus_wren && (bus_addr == 16'hFFFF);
        if_wr          = bus_wren && (bus_addr == 16'hFF0F);
        pending        = ie_q[4:0] & if_q;
        any_pending    = |pending;
        active         = (state_q != IDLE);
        dispatch_clear = (state_q == D5) ? clr_q : 5'd0;
        ie_d           = ie_wr ? bus_wdata : ie_q;
        // A fresh request beats both a bus write and the dispatch clear.
        if_d           = ((if_wr ? bus_wdata[4:0] : if_q) & ~dispatch_clear) | irq_req;
        start          = !active && ime_q && any_pending && (last_m_cycle || halt);

        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? D1 : IDLE;
            D1:      state_d = D2;
            D2:      state_d = D3;
            D3:      state_d = D4;
            D4:      state_d = D5;
            default: state_d = IDLE;
        endcase

        // Resolve against IE/IF as they will stand after the PC-high push.
        vec_d        = vec_q;
        clr_d        = clr_q;
        pend_resolve = ie_d[4:0] & if_d;
        if (state_q == D3) begin
            vec_d = 8'h00;
            clr_d = 5'd0;
            for (int n = 4; n >= 0; n--) begin
                if (pend_resolve[n]) begin
                    vec_d = 8'h40 | {2'b00, 3'(n), 3'b000};
                    clr_d = 5'd1 << n;
                end
            end
        end

        ime_d      = ime_q;
        ime_pend_d = ime_pend_q;
        if (start) begin
            ime_d      = 1'b0;
            ime_pend_d = 1'b0;
        end else if (!active) begin
            if (di_cmd) begin
                ime_d      = 1'b0;
                ime_pend_d = 1'b0;
            end else begin
                if (reti_cmd && last_m_cycle) ime_d = 1'b1;
                if (ime_pend_q && last_m_cycle) begin
                    ime_d      = 1'b1;
                    ime_pend_d = 1'b0;
                end
                if (ei_cmd && last_m_cycle) ime_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ie_q       <= 8'h00;
            if_q       <= 5'h01;
            ime_q      <= 1'b0;
            ime_pend_q <= 1'b0;
            vec_q      <= 8'h00;
            clr_q      <= 5'd0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            if_q       <= if_d;
            ime_q      <= ime_d;
            ime_pend_q <= ime_pend_d;
            vec_q      <= vec_d;
            clr_q      <= clr_d;
        end
    end

    assign ie_reg                  = ie_q;
    assign if_reg                  = {3'b111, if_q};
    assign ime                     = ime_q;
    assign interrupt_queued        = ime_q && any_pending;
    assign interrupt_queued_no_IME = !ime_q && any_pending;
    assign dispatch_active         = active;
    assign dispatch_step           = state_q;
    assign write_interrupt_vector  = (state_q == D5);
    assign interrupt_vector        = (state_q == D5) ? vec_q : 8'h00;

endmodule
